// File: rtl/ddr_dqs_rcvr_cal_pkg.sv
// Shared types and helpers for the DQS receiver enable / offset-calibration controller.
package ddr_dqs_rcvr_cal_pkg;

    // Calibration sequencer states.
    typedef enum logic [1:0] {
        CAL_IDLE   = 2'd0,
        CAL_SETTLE = 2'd1,
        CAL_SAMPLE = 2'd2,
        CAL_DONE   = 2'd3
    } cal_state_e;

    // Mid-scale cal code, used at reset and for channels that never flip.
    function automatic int unsigned cal_def(input int unsigned cal_w);
        return 32'd1 << (cal_w - 1);
    endfunction

endpackage

// File: rtl/ddr_dqs_rcvr_cal_ctrl_if.sv
// Bus between the CSR/datapath side and the receiver controller.
//
// Handshake: there is no valid/ready pair. i_cal_start is a single-cycle
// request that is accepted only while the sequencer is idle. o_cal_busy
// covers the whole run, and o_cal_done pulses for one cycle in its last cycle.
interface ddr_dqs_rcvr_cal_ctrl_if #(
    parameter int NUM_CH   = 2,
    parameter int CAL_W    = 4,
    parameter int SETTLE_W = 6
);
    import ddr_dqs_rcvr_cal_pkg::*;

    logic [NUM_CH-1:0]       i_ie;
    logic                    i_sw_ovr;
    logic                    i_sw_en;
    logic                    i_cal_start;
    logic [SETTLE_W-1:0]     i_settle_cycles;
    logic [NUM_CH-1:0]       i_rcvr_out;

    logic [NUM_CH-1:0]       o_ena;
    logic                    o_rxcal_ena;
    logic [NUM_CH*CAL_W-1:0] o_cal_code;
    logic                    o_cal_busy;
    logic                    o_cal_done;
    logic [NUM_CH-1:0]       o_cal_err;
    cal_state_e              o_cal_state;  // debug view of the sequencer state

    modport master (
        output i_ie, i_sw_ovr, i_sw_en, i_cal_start, i_settle_cycles, i_rcvr_out,
        input  o_ena, o_rxcal_ena, o_cal_code, o_cal_busy, o_cal_done, o_cal_err, o_cal_state
    );

    modport slave (
        input  i_ie, i_sw_ovr, i_sw_en, i_cal_start, i_settle_cycles, i_rcvr_out,
        output o_ena, o_rxcal_ena, o_cal_code, o_cal_busy, o_cal_done, o_cal_err, o_cal_state
    );

endinterface

// File: rtl/ddr_dqs_rcvr_cal_fsm.sv
// Calibration sequencer: walks the step code upward from 0 and holds each
// code for a programmable settle time before one sample cycle.
module ddr_dqs_rcvr_cal_fsm
    import ddr_dqs_rcvr_cal_pkg::*;
#(
    parameter int CAL_W    = 4,
    parameter int SETTLE_W = 6
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [SETTLE_W-1:0] settle_i,
    input  logic                all_found_i,
    output cal_state_e          state_o,
    output logic [CAL_W-1:0]    step_o,
    output logic                accept_o,
    output logic                busy_next_o,
    output logic                busy_o,
    output logic                rxcal_o,
    output logic                done_o
);

    cal_state_e          state_q;
    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [CAL_W-1:0]    step_q;
    logic                busy_q;
    logic                rxcal_q;
    logic                done_q;

    // The start request is only honoured from idle.
    assign accept_o = (state_q == CAL_IDLE) && start_i;

    // Busy in the next cycle; lets the enable register line up with busy.
    assign busy_next_o = accept_o || (state_q == CAL_SETTLE) || (state_q == CAL_SAMPLE);

    // Sequencer state, settle counter, step code and registered status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= CAL_IDLE;
            cnt_q    <= '0;
            settle_q <= '0;
            step_q   <= '0;
            busy_q   <= 1'b0;
            rxcal_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                CAL_IDLE: begin
                    if (start_i) begin
                        state_q  <= CAL_SETTLE;
                        step_q   <= '0;
                        cnt_q    <= settle_i;
                        settle_q <= settle_i;
                        busy_q   <= 1'b1;
                        rxcal_q  <= 1'b1;
                    end
                end
                CAL_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= CAL_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                CAL_SAMPLE: begin
                    // Terminal check precedes the increment so the code never wraps.
                    if (all_found_i || (step_q == '1)) begin
                        state_q <= CAL_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        step_q  <= step_q + 1'b1;
                        cnt_q   <= settle_q;
                        state_q <= CAL_SETTLE;
                    end
                end
                CAL_DONE: begin
                    state_q <= CAL_IDLE;
                    busy_q  <= 1'b0;
                    rxcal_q <= 1'b0;
                end
                default: begin
                    state_q <= CAL_IDLE;
                    busy_q  <= 1'b0;
                    rxcal_q <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign step_o  = step_q;
    assign busy_o  = busy_q;
    assign rxcal_o = rxcal_q;
    assign done_o  = done_q;

endmodule

// File: rtl/ddr_dqs_rcvr_cal_ctrl.sv
// Multi-channel DQS receiver controller: registered enable muxing plus an
// offset-calibration sweep that latches each channel's first flip code.
module ddr_dqs_rcvr_cal_ctrl
    import ddr_dqs_rcvr_cal_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int CAL_W    = 4,
    parameter int SETTLE_W = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    ddr_dqs_rcvr_cal_ctrl_if.slave bus
);

    localparam logic [CAL_W-1:0] CAL_DEF = CAL_W'(cal_def(CAL_W));

    cal_state_e              state;
    logic [CAL_W-1:0]        step;
    logic                    accept;
    logic                    busy_next;
    logic                    busy;
    logic                    rxcal;
    logic                    done;
    logic                    sample;
    logic                    in_done;
    logic                    all_found;
    logic                    ref_valid_q;
    logic [NUM_CH-1:0]       ena_q;
    logic [NUM_CH-1:0]       found_v;
    logic [NUM_CH-1:0]       hit_v;
    logic [NUM_CH-1:0]       err_v;
    logic [NUM_CH*CAL_W-1:0] code_v;

    ddr_dqs_rcvr_cal_fsm #(
        .CAL_W    (CAL_W),
        .SETTLE_W (SETTLE_W)
    ) u_fsm (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .start_i     (bus.i_cal_start),
        .settle_i    (bus.i_settle_cycles),
        .all_found_i (all_found),
        .state_o     (state),
        .step_o      (step),
        .accept_o    (accept),
        .busy_next_o (busy_next),
        .busy_o      (busy),
        .rxcal_o     (rxcal),
        .done_o      (done)
    );

    assign sample  = (state == CAL_SAMPLE);
    assign in_done = (state == CAL_DONE);

    // A channel counts as found if it already was, or flips in this sample.
    assign all_found = &(found_v | hit_v);

    // Receiver enable: forced on for the whole calibration, otherwise IE/override mux.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ena_q <= '0;
        end else if (busy_next) begin
            ena_q <= '1;
        end else if (bus.i_sw_ovr) begin
            ena_q <= {NUM_CH{bus.i_sw_en}};
        end else begin
            ena_q <= bus.i_ie | {NUM_CH{bus.i_sw_en}};
        end
    end

    // The first sample (code 0) only captures the reference comparator level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ref_valid_q <= 1'b0;
        end else if (accept) begin
            ref_valid_q <= 1'b0;
        end else if (sample) begin
            ref_valid_q <= 1'b1;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic             found_q;
        logic             ref_q;
        logic             err_q;
        logic [CAL_W-1:0] result_q;

        assign hit_v[ch] = ref_valid_q && !found_q && (bus.i_rcvr_out[ch] != ref_q);

        // Per-channel reference, found flag, latched result and sticky error.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                found_q  <= 1'b0;
                ref_q    <= 1'b0;
                err_q    <= 1'b0;
                result_q <= CAL_DEF;
            end else if (accept) begin
                found_q <= 1'b0;
                ref_q   <= 1'b0;
                err_q   <= 1'b0;
            end else if (sample) begin
                if (!ref_valid_q) begin
                    ref_q <= bus.i_rcvr_out[ch];
                end else if (hit_v[ch]) begin
                    found_q  <= 1'b1;
                    result_q <= step;
                end
            end else if (in_done && !found_q) begin
                err_q    <= 1'b1;
                result_q <= CAL_DEF;
            end
        end

        assign found_v[ch] = found_q;
        assign err_v[ch]   = err_q;
        assign code_v[ch*CAL_W +: CAL_W] = rxcal ? step : result_q;
    end

    assign bus.o_ena       = ena_q;
    assign bus.o_rxcal_ena = rxcal;
    assign bus.o_cal_code  = code_v;
    assign bus.o_cal_busy  = busy;
    assign bus.o_cal_done  = done;
    assign bus.o_cal_err   = err_v;
    assign bus.o_cal_state = state;

endmodule

// File: tb/tb_ddr_dqs_rcvr_cal_ctrl.sv
// Directed bench for the DQS receiver enable / calibration controller.
module tb_ddr_dqs_rcvr_cal_ctrl;
  import ddr_dqs_rcvr_cal_pkg::*;

  logic clk;
  logic rst;
  logic [4:0] flip0;
  logic [4:0] flip1;
  int n_chk;
  int n_pass;

  ddr_dqs_rcvr_cal_ctrl_if #(.NUM_CH(2), .CAL_W(4), .SETTLE_W(6)) bus ();

  ddr_dqs_rcvr_cal_ctrl #(.NUM_CH(2), .CAL_W(4), .SETTLE_W(6)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // comparator model: channel output goes high once the applied code reaches its flip code
  always_comb begin
    bus.i_rcvr_out = '0;
    bus.i_rcvr_out[0] = ({1'b0, bus.o_cal_code[3:0]} >= flip0);
    bus.i_rcvr_out[1] = ({1'b0, bus.o_cal_code[7:4]} >= flip1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_ie = '0;
    bus.i_sw_ovr = 1'b0;
    bus.i_sw_en = 1'b0;
    bus.i_cal_start = 1'b0;
    bus.i_settle_cycles = '0;
    flip0 = 5'd16;
    flip1 = 5'd16;
    repeat (2) step_clk();
    rst = 1'b0;
    step_clk();
  endtask

  // Pulse start and run to the end of calibration; extra>0 re-pulses start at that cycle.
  task automatic run_cal(input string tag, input int settle, input int f0, input int f1,
                         input int extra, input int exp_done, input int exp_code, input int exp_err);
    int n;
    int ena_bad;
    bus.i_settle_cycles = 6'(settle);
    flip0 = 5'(f0);
    flip1 = 5'(f1);
    bus.i_ie = '0;
    bus.i_sw_ovr = 1'b0;
    bus.i_sw_en = 1'b0;
    bus.i_cal_start = 1'b1;
    step_clk();
    bus.i_cal_start = 1'b0;
    n = 1;
    check({tag, "_busy1"}, 32'(bus.o_cal_busy), 32'd1);
    check({tag, "_rxcal1"}, 32'(bus.o_rxcal_ena), 32'd1);
    ena_bad = 0;
    while (!bus.o_cal_done && n < 400) begin
      if (bus.o_ena !== 2'b11 || bus.o_cal_busy !== 1'b1) ena_bad++;
      bus.i_cal_start = (extra > 0 && n == extra);
      step_clk();
      bus.i_cal_start = 1'b0;
      n++;
    end
    check({tag, "_done_cyc"}, 32'(n), 32'(exp_done));
    check({tag, "_ena_busy"}, 32'(ena_bad), 32'd0);
    check({tag, "_ena_done"}, 32'(bus.o_ena), 32'h3);
    check({tag, "_busy_done"}, 32'(bus.o_cal_busy), 32'd1);
    step_clk();
    check({tag, "_busy_after"}, 32'(bus.o_cal_busy), 32'd0);
    check({tag, "_rxcal_after"}, 32'(bus.o_rxcal_ena), 32'd0);
    check({tag, "_done_pulse"}, 32'(bus.o_cal_done), 32'd0);
    check({tag, "_code"}, 32'(bus.o_cal_code), 32'(exp_code));
    check({tag, "_err"}, 32'(bus.o_cal_err), 32'(exp_err));
    check({tag, "_ena_after"}, 32'(bus.o_ena), 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    do_reset();

    // reset values
    check("rst_ena", 32'(bus.o_ena), 32'd0);
    check("rst_rxcal", 32'(bus.o_rxcal_ena), 32'd0);
    check("rst_busy", 32'(bus.o_cal_busy), 32'd0);
    check("rst_done", 32'(bus.o_cal_done), 32'd0);
    check("rst_err", 32'(bus.o_cal_err), 32'd0);
    check("rst_code", 32'(bus.o_cal_code), 32'h88);
    check("rst_state", 32'(bus.o_cal_state), 32'(CAL_IDLE));

    // enable path, one-cycle latency
    bus.i_ie = 2'b01;
    check("ena_lat", 32'(bus.o_ena), 32'd0);
    step_clk();
    check("ena_ie", 32'(bus.o_ena), 32'h1);
    bus.i_sw_ovr = 1'b1;
    step_clk();
    check("ena_ovr0", 32'(bus.o_ena), 32'h0);
    bus.i_sw_en = 1'b1;
    step_clk();
    check("ena_ovr1", 32'(bus.o_ena), 32'h3);
    bus.i_sw_ovr = 1'b0;
    bus.i_sw_en = 1'b0;
    bus.i_ie = 2'b10;
    step_clk();
    check("ena_ie2", 32'(bus.o_ena), 32'h2);

    // flip at 5 / 9, settle 3: 10 steps of 5 cycles
    run_cal("flip", 3, 5, 9, 0, 51, 32'h95, 0);

    // ch1 never flips, settle 0: full 16-step sweep
    run_cal("noflip", 0, 3, 16, 0, 33, 32'h83, 2);

    // repeated start mid-sweep is ignored
    run_cal("restart", 3, 5, 9, 20, 51, 32'h95, 0);

    // async reset during SETTLE of step 7 (cycles 36..39 after start)
    begin
      int n;
      bus.i_settle_cycles = 6'd3;
      flip0 = 5'd5;
      flip1 = 5'd9;
      bus.i_cal_start = 1'b1;
      step_clk();
      bus.i_cal_start = 1'b0;
      n = 1;
      while (n < 38) begin
        step_clk();
        n++;
      end
      check("mid_state", 32'(bus.o_cal_state), 32'(CAL_SETTLE));
      check("mid_code", 32'(bus.o_cal_code), 32'h77);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(bus.o_cal_busy), 32'd0);
      check("mid_rst_rxcal", 32'(bus.o_rxcal_ena), 32'd0);
      check("mid_rst_code", 32'(bus.o_cal_code), 32'h88);
      check("mid_rst_ena", 32'(bus.o_ena), 32'd0);
      check("mid_rst_state", 32'(bus.o_cal_state), 32'(CAL_IDLE));
      step_clk();
      rst = 1'b0;
      step_clk();
    end
    run_cal("post_rst", 3, 5, 9, 0, 51, 32'h95, 0);

    // early exit: both flip at code 1
    run_cal("early0", 0, 1, 1, 0, 5, 32'h11, 0);
    run_cal("early63", 63, 1, 1, 0, 131, 32'h11, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ddr_dqs_rcvr_cal_ctrl.md
# ddr_dqs_rcvr_cal_ctrl

Parametrised multi-channel controller for the DQS receiver analog macros. It registers the per-channel receiver enable (IE/software-override muxing, generalised to NUM_CH channels) and adds an offset-calibration sequencer. The sequencer forces the receivers into rxcal mode and sweeps the cal code with a programmable settle time. It latches, per channel, the first code at which the comparator output flips. It sits between the CSR block and the per-channel receiver wrappers, driving their ena, rxcal_ena and cal-code inputs.

## Interface
- NUM_CH, 2, number of receiver channels (>=1)
- CAL_W, 4, cal code width per channel
- SETTLE_W, 6, settle counter width
- i_clk  input  1  clock
- i_rst  input  1  reset, asynchronous, active-high
- i_ie  input  NUM_CH  per-channel input enable from datapath
- i_sw_ovr  input  1  software override select
- i_sw_en  input  1  software enable value
- i_cal_start  input  1  single-cycle calibration request
- i_settle_cycles  input  SETTLE_W  settle cycles per code step (sampled at start)
- i_rcvr_out  input  NUM_CH  receiver comparator output, already synchronised to i_clk
- o_ena  output  NUM_CH  receiver enable (drives d_ena and d_edge_det_ena)
- o_rxcal_ena  output  1  rxcal mode enable
- o_cal_code  output  NUM_CH*CAL_W  current cal code, channel ch in bits [ch*CAL_W +: CAL_W]
- o_cal_busy  output  1  calibration in progress
- o_cal_done  output  1  one-cycle pulse at end of calibration
- o_cal_err  output  NUM_CH  sticky: channel never flipped during the last calibration

## Operation
- Enable path, registered: when not busy, o_ena[ch] <= i_sw_ovr ? i_sw_en : (i_ie[ch] | i_sw_en). When busy, o_ena <= all ones.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - When i_cal_start=1, go to SETTLE.
  - Load step code = 0 and cnt = i_settle_cycles.
  - Clear found[], ref_valid and o_cal_err.
  - i_cal_start in any other state is ignored.
- SETTLE:
  - o_rxcal_ena=1; every channel's o_cal_code = step code.
  - Decrement cnt; when cnt==0, go to SAMPLE.
- SAMPLE, one cycle:
  - If !ref_valid: capture ref[ch] = i_rcvr_out[ch] and set ref_valid.
  - Otherwise, for each channel with !found[ch] and i_rcvr_out[ch] != ref[ch]: result[ch] = step code, found[ch] = 1.
  - If all channels are found, or step code == 2^CAL_W-1, go to DONE. Otherwise increment step code, reload cnt and go to SETTLE.
- DONE, one cycle:
  - o_cal_done=1.
  - For each channel with !found[ch]: o_cal_err[ch]=1 and result[ch] = CAL_DEF.
  - Go to IDLE.
- Outside calibration: o_rxcal_ena=0 and o_cal_code = result[] (the latched results).
- Code 0 only establishes ref and is never reported as a result.
- Step code must not wrap; the terminal check happens before increment.

## Timing
- Reset values:
  - o_ena=0, o_rxcal_ena=0, o_cal_busy=0, o_cal_done=0, o_cal_err=0.
  - result[] = CAL_DEF = 2^(CAL_W-1).
  - FSM in IDLE.
- o_ena has one-cycle latency from i_ie, i_sw_ovr and i_sw_en.
- i_cal_start at cycle T:
  - o_cal_busy and o_rxcal_ena are high from T+1.
  - Both stay high through the DONE cycle.
- Each code step lasts i_settle_cycles+2 cycles (SETTLE i_settle_cycles+1, SAMPLE 1). i_settle_cycles=0 is legal and gives 2 cycles per step.
- Full sweep, no flip: 2^CAL_W steps plus the DONE cycle.
- In the cycle after DONE, o_cal_busy=0 and o_cal_code shows the results.
- Asserting i_rst mid-calibration returns every output to its reset value immediately. Stale found, ref and step state is not retained.

## Structure
- Shared package ddr_dqs_rcvr_cal_pkg holds:
  - the FSM state enum;
  - the CAL_DEF function of CAL_W.
- One natural sub-module: ddr_dqs_rcvr_cal_fsm (state, counter, step code). The per-channel found/ref/result registers are a generate loop in the top module.

## Test plan
All cases use NUM_CH=2, CAL_W=4.
- Reset, then i_ie=2'b01, i_sw_ovr=0, i_sw_en=0 -> o_ena=2'b01 one cycle later. Then i_sw_ovr=1, i_sw_en=0 -> o_ena=2'b00. Then i_sw_en=1 -> o_ena=2'b11.
- Calibration flip case:
  - Stimulus: settle=3; ch0 flips from code 5, ch1 from code 9.
  - Response: results 5 and 9, o_cal_err=0.
  - Response: o_cal_done at cycle 10*5+1 = 51 after start.
  - Response: o_ena=2'b11 throughout busy.
- Calibration, ch1 never flips, settle=0 -> ch1 code 8 (CAL_DEF), o_cal_err=2'b10, full sweep of 16 steps, o_cal_done at T+33.
- Second i_cal_start pulse mid-sweep -> ignored; codes and timing are identical to the single-start run.
- Assert i_rst during SETTLE of step 7 -> immediately o_cal_busy=0, o_rxcal_ena=0, codes 8/8. A new start afterwards completes correctly.
- Comparator already flipping at code 1 on both channels -> early exit after 2 steps with codes 1/1. The same case with settle=63 checks the counter at its maximum value.
